// File: rtl/unsat_clause_fifo_if.sv
// Handshake/data bundle between the unsat clause FIFO and its producer/consumer.
// master drives push/pop/clear controls; slave is the FIFO itself.
interface unsat_clause_fifo_if #(
  parameter int FIFO_DEPTH            = 16,
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 12
);
  localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CLAUSE_WIDTH    = NSAT * LITERAL_ADDRESS_WIDTH;

  logic                       clear_i;
  logic                       push_i;
  logic [CLAUSE_WIDTH-1:0]    push_clause_i;
  logic                       pop_i;
  logic                       clear_overflow_i;
  logic                       empty_o;
  logic                       full_o;
  logic                       last_o;
  logic [CLAUSE_WIDTH-1:0]    clause_o;
  logic [FIFO_ADDR_WIDTH:0]   count_o;
  logic                       overflow_o;
  logic [FIFO_ADDR_WIDTH:0]   high_water_o;

  modport master (
    output clear_i, push_i, push_clause_i, pop_i, clear_overflow_i,
    input  empty_o, full_o, last_o, clause_o, count_o, overflow_o, high_water_o
  );

  modport slave (
    input  clear_i, push_i, push_clause_i, pop_i, clear_overflow_i,
    output empty_o, full_o, last_o, clause_o, count_o, overflow_o, high_water_o
  );
endinterface

// File: rtl/unsat_clause_fifo.sv
// First-word-fall-through FIFO of newly unsatisfied clauses, with last-entry flag,
// sticky overflow and high-water mark. Occupancy count is the only control state.
module unsat_clause_fifo #(
  parameter int FIFO_DEPTH            = 16,
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  unsat_clause_fifo_if.slave   bus
);
  localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CLAUSE_WIDTH    = NSAT * LITERAL_ADDRESS_WIDTH;
  localparam int CNT_W           = FIFO_ADDR_WIDTH + 1;

  logic [CLAUSE_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [CNT_W-1:0]           high_water_q, high_water_d;
  logic                       overflow_q, overflow_d;

  logic empty, full;
  logic acc_push, acc_pop, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    acc_push     = 1'b0;
    acc_pop      = 1'b0;
    drop         = 1'b0;

    if (bus.clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // A pop frees the slot in the same cycle, so a push while full is accepted with a pop.
      acc_push = bus.push_i & (~full | bus.pop_i);
      acc_pop  = bus.pop_i & ~empty;
      drop     = bus.push_i & full & ~bus.pop_i;
      if (acc_push) wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
      if (acc_pop)  rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
      count_d = count_q + CNT_W'(acc_push) - CNT_W'(acc_pop);
    end

    overflow_d = drop | (overflow_q & ~bus.clear_overflow_i);

    if (bus.clear_overflow_i)         high_water_d = count_d;
    else if (count_d > high_water_q)  high_water_d = count_d;
    else                              high_water_d = high_water_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      high_water_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      high_water_q <= high_water_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (acc_push) mem_q[wr_ptr_q] <= bus.push_clause_i;
  end

  assign bus.clause_o     = mem_q[rd_ptr_q];
  assign bus.empty_o      = empty;
  assign bus.full_o       = full;
  assign bus.last_o       = (count_q == CNT_W'(1));
  assign bus.count_o      = count_q;
  assign bus.overflow_o   = overflow_q;
  assign bus.high_water_o = high_water_q;
endmodule

// File: tb/tb_unsat_clause_fifo.sv
// Directed self-checking bench for unsat_clause_fifo (depth 16, 3x12-bit clauses).
module tb_unsat_clause_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  unsat_clause_fifo_if #(.FIFO_DEPTH(DEPTH), .NSAT(3), .LITERAL_ADDRESS_WIDTH(12)) bus ();

  unsat_clause_fifo #(.FIFO_DEPTH(DEPTH), .NSAT(3), .LITERAL_ADDRESS_WIDTH(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic push, input logic [CW-1:0] d, input logic pop);
    bus.push_i        = push;
    bus.push_clause_i = d;
    bus.pop_i         = pop;
  endtask

  function automatic logic [CW-1:0] fill_val(input int i);
    return CW'(36'h100 + i);
  endfunction

  logic [CW-1:0] exp_head;

  initial begin
    bus.clear_i          = 1'b0;
    bus.clear_overflow_i = 1'b0;
    drive(1'b0, '0, 1'b0);

    // Reset state
    tick(); tick();
    chk("rst_count", 64'(bus.count_o), 0);
    chk("rst_empty", 64'(bus.empty_o), 1);
    chk("rst_full",  64'(bus.full_o), 0);
    chk("rst_last",  64'(bus.last_o), 0);
    chk("rst_ovf",   64'(bus.overflow_o), 0);
    chk("rst_hw",    64'(bus.high_water_o), 0);
    rst = 1'b0;
    tick();

    // 1. Push A, B, C
    drive(1'b1, 36'h001002003, 1'b0); tick();
    chk("t1_a_head",  64'(bus.clause_o), 64'h001002003);
    chk("t1_a_empty", 64'(bus.empty_o), 0);
    chk("t1_a_last",  64'(bus.last_o), 1);
    drive(1'b1, 36'h004005006, 1'b0); tick();
    drive(1'b1, 36'h007008009, 1'b0); tick();
    drive(1'b0, '0, 1'b0);
    chk("t1_count", 64'(bus.count_o), 3);
    chk("t1_hw",    64'(bus.high_water_o), 3);
    chk("t1_last",  64'(bus.last_o), 0);
    chk("t1_empty", 64'(bus.empty_o), 0);
    chk("t1_head",  64'(bus.clause_o), 64'h001002003);

    // 2. Pop three times, then once more while empty
    drive(1'b0, '0, 1'b1); tick();
    chk("t2_head_b", 64'(bus.clause_o), 64'h004005006);
    chk("t2_cnt2",   64'(bus.count_o), 2);
    tick();
    chk("t2_head_c", 64'(bus.clause_o), 64'h007008009);
    chk("t2_last1",  64'(bus.last_o), 1);
    chk("t2_cnt1",   64'(bus.count_o), 1);
    tick();
    chk("t2_empty",  64'(bus.empty_o), 1);
    chk("t2_cnt0",   64'(bus.count_o), 0);
    chk("t2_last0",  64'(bus.last_o), 0);
    tick();
    chk("t2_pop4_cnt", 64'(bus.count_o), 0);
    chk("t2_pop4_hw",  64'(bus.high_water_o), 3);

    // Pop while empty with a push: push stored, count 0 -> 1
    drive(1'b1, 36'hABCDEF012, 1'b1); tick();
    chk("pe_count", 64'(bus.count_o), 1);
    chk("pe_head",  64'(bus.clause_o), 64'hABCDEF012);
    drive(1'b0, '0, 1'b1); tick();
    chk("pe_drain", 64'(bus.empty_o), 1);

    // 3. Fill 16, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, fill_val(i), 1'b0); tick();
    end
    chk("t3_full",  64'(bus.full_o), 1);
    chk("t3_count", 64'(bus.count_o), 16);
    chk("t3_hw",    64'(bus.high_water_o), 16);
    chk("t3_ovf0",  64'(bus.overflow_o), 0);
    drive(1'b1, 36'hDEADDEAD0, 1'b0); tick();
    chk("t3_drop_count", 64'(bus.count_o), 16);
    chk("t3_drop_ovf",   64'(bus.overflow_o), 1);
    chk("t3_drop_head",  64'(bus.clause_o), 64'(fill_val(0)));
    // Dropped push with clear_overflow in the same cycle: set wins
    bus.clear_overflow_i = 1'b1;
    drive(1'b1, 36'hDEADDEAD1, 1'b0); tick();
    bus.clear_overflow_i = 1'b0;
    chk("t3_setwins_ovf", 64'(bus.overflow_o), 1);
    chk("t3_setwins_hw",  64'(bus.high_water_o), 16);
    // Push and pop together while full
    drive(1'b1, 36'h0BEEF0BEE, 1'b1); tick();
    chk("t3_pp_count", 64'(bus.count_o), 16);
    chk("t3_pp_full",  64'(bus.full_o), 1);
    drive(1'b0, '0, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("t3_drain_%0d", i), 64'(bus.clause_o), 64'(fill_val(i)));
      tick();
    end
    chk("t3_drain_new",  64'(bus.clause_o), 64'h0BEEF0BEE);
    chk("t3_drain_last", 64'(bus.last_o), 1);
    tick();
    chk("t3_drained", 64'(bus.empty_o), 1);

    // 4. 40 cycles of push+pop at count 1
    exp_head = 36'h200000000;
    drive(1'b1, exp_head, 1'b0); tick();
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("t4_head_%0d", k), 64'(bus.clause_o), 64'(exp_head));
      chk($sformatf("t4_cnt_%0d", k),  64'(bus.count_o), 1);
      drive(1'b1, CW'(36'h300000000 + k * 7), 1'b1); tick();
      exp_head = CW'(36'h300000000 + k * 7);
    end
    chk("t4_final_head", 64'(bus.clause_o), 64'(exp_head));
    drive(1'b0, '0, 1'b1); tick();
    chk("t4_empty", 64'(bus.empty_o), 1);

    // 5. clear_i with push and pop at count 5
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, fill_val(40 + i), 1'b0); tick();
    end
    chk("t5_pre_count", 64'(bus.count_o), 5);
    bus.clear_i = 1'b1;
    drive(1'b1, 36'h111111111, 1'b1); tick();
    bus.clear_i = 1'b0;
    drive(1'b0, '0, 1'b0);
    chk("t5_count", 64'(bus.count_o), 0);
    chk("t5_empty", 64'(bus.empty_o), 1);
    chk("t5_ovf",   64'(bus.overflow_o), 1);
    chk("t5_hw",    64'(bus.high_water_o), 16);
    bus.clear_overflow_i = 1'b1; tick();
    chk("co_ovf", 64'(bus.overflow_o), 0);
    chk("co_hw",  64'(bus.high_water_o), 0);
    drive(1'b1, 36'h222222222, 1'b0); tick();
    bus.clear_overflow_i = 1'b0;
    chk("co_push_hw", 64'(bus.high_water_o), 1);
    drive(1'b1, 36'h333333333, 1'b0); tick();
    drive(1'b1, 36'h444444444, 1'b0); tick();
    drive(1'b0, '0, 1'b0);
    chk("t6_pre_count", 64'(bus.count_o), 3);

    // 6. Asynchronous reset between clock edges
    #3 rst = 1'b1;
    #1;
    chk("t6_count", 64'(bus.count_o), 0);
    chk("t6_empty", 64'(bus.empty_o), 1);
    chk("t6_full",  64'(bus.full_o), 0);
    chk("t6_last",  64'(bus.last_o), 0);
    chk("t6_ovf",   64'(bus.overflow_o), 0);
    chk("t6_hw",    64'(bus.high_water_o), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_post_empty", 64'(bus.empty_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
